// File: rtl/regbus_write_sequencer.sv
// Register-write bus initiator: queues write commands in a small FIFO and replays
// each one on the bus with timed setup, strobe and hold windows.
module regbus_write_sequencer #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 100,
  parameter int HOLD_CYC   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [DATA_W-1:0]           cmd_data,
  output logic                        write_strobe,
  output logic [ADDR_W-1:0]           address,
  output logic [DATA_W-1:0]           data,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int WORD_W  = ADDR_W + DATA_W;
  localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [PTR_W:0]   DEPTH_V     = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE     = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_ZERO    = (PTR_W+1)'(0);
  localparam logic [PTR_W-1:0] PTR_ONE     = PTR_W'(1);
  localparam logic [CNT_W-1:0] TMR_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] TMR_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   tmr_r;
  logic [PTR_W:0]     count_r;
  logic [PTR_W:0]     count_nxt_s;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [WORD_W-1:0]  mem_r [FIFO_DEPTH];
  logic [WORD_W-1:0]  head_s;
  logic               push_s;
  logic               pop_s;

  // A full queue refuses pushes even when it pops in the same cycle.
  assign cmd_ready  = !rst && (count_r < DEPTH_V);
  assign push_s     = cmd_valid && cmd_ready;
  assign fifo_count = count_r;
  assign head_s     = mem_r[rd_ptr_r];

  // Pop decision: from IDLE whenever work is queued, or on the last HOLD cycle.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE:    pop_s = (count_r != CNT_ZERO);
      HOLD:    pop_s = (tmr_r == HOLD_LAST) && (count_r != CNT_ZERO);
      default: pop_s = 1'b0;
    endcase
  end

  // Next queue occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!push_s && pop_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Queue storage; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cmd_addr, cmd_data};
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Bus sequencer: one shared window timer counts up to each window's last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      tmr_r        <= TMR_ZERO;
      write_strobe <= 1'b0;
      address      <= '0;
      data         <= '0;
      busy         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r <= SETUP;
            tmr_r   <= TMR_ZERO;
            address <= head_s[WORD_W-1:DATA_W];
            data    <= head_s[DATA_W-1:0];
            busy    <= 1'b1;
          end else begin
            busy    <= (count_nxt_s != CNT_ZERO);
          end
        end
        SETUP: begin
          busy <= 1'b1;
          if (tmr_r == SETUP_LAST) begin
            state_r      <= STROBE;
            tmr_r        <= TMR_ZERO;
            write_strobe <= 1'b1;
          end else begin
            tmr_r <= tmr_r + TMR_ONE;
          end
        end
        STROBE: begin
          busy <= 1'b1;
          if (tmr_r == STROBE_LAST) begin
            state_r      <= HOLD;
            tmr_r        <= TMR_ZERO;
            write_strobe <= 1'b0;
          end else begin
            tmr_r <= tmr_r + TMR_ONE;
          end
        end
        HOLD: begin
          if (tmr_r == HOLD_LAST) begin
            tmr_r <= TMR_ZERO;
            if (pop_s) begin
              state_r <= SETUP;
              address <= head_s[WORD_W-1:DATA_W];
              data    <= head_s[DATA_W-1:0];
              busy    <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy    <= (count_nxt_s != CNT_ZERO);
            end
          end else begin
            tmr_r <= tmr_r + TMR_ONE;
            busy  <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          tmr_r        <= TMR_ZERO;
          write_strobe <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbus_write_sequencer.sv
// Directed bench for regbus_write_sequencer: default timing instance plus a
// 1/1/1-cycle instance for the minimum-window case.
module tb_regbus_write_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_addr = 3'd0;
  logic [4:0] cmd_data = 5'd0;
  logic       write_strobe;
  logic [2:0] address;
  logic [4:0] data;
  logic       busy;
  logic [2:0] fifo_count;

  logic       f_cmd_valid = 1'b0;
  logic       f_cmd_ready;
  logic [2:0] f_cmd_addr = 3'd0;
  logic [4:0] f_cmd_data = 5'd0;
  logic       f_write_strobe;
  logic [2:0] f_address;
  logic [4:0] f_data;
  logic       f_busy;
  logic [2:0] f_fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int         rise_q[$];
  int         fall_q[$];
  logic [7:0] wr_q[$];
  int         f_rise_q[$];
  int         f_fall_q[$];
  logic [7:0] f_wr_q[$];
  logic       ws_d = 1'b0;
  logic       f_ws_d = 1'b0;

  regbus_write_sequencer u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .write_strobe(write_strobe),
    .address(address), .data(data), .busy(busy), .fifo_count(fifo_count)
  );

  regbus_write_sequencer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_dut_fast (
    .clk(clk), .rst(rst), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_addr(f_cmd_addr), .cmd_data(f_cmd_data), .write_strobe(f_write_strobe),
    .address(f_address), .data(f_data), .busy(f_busy), .fifo_count(f_fifo_count)
  );

  always #5 clk = ~clk;

  // Edge index: value seen at a negedge is the number of the last rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe edge recorder for both instances.
  always @(negedge clk) begin
    if (write_strobe && !ws_d) begin
      rise_q.push_back(cyc);
      wr_q.push_back({address, data});
    end
    if (!write_strobe && ws_d) fall_q.push_back(cyc);
    ws_d <= write_strobe;
    if (f_write_strobe && !f_ws_d) begin
      f_rise_q.push_back(cyc);
      f_wr_q.push_back({f_address, f_data});
    end
    if (!f_write_strobe && f_ws_d) f_fall_q.push_back(cyc);
    f_ws_d <= f_write_strobe;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int g = 0;
    while ((busy || fifo_count != 3'd0) && g < max_cyc) begin
      @(negedge clk);
      g++;
    end
    check_eq(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic clear_log();
    rise_q.delete(); fall_q.delete(); wr_q.delete();
  endtask

  int e0;
  int acc_cyc [6];
  int guard;
  logic accepted;
  logic full_checked;

  initial begin
    // ---------------- Test 1: reset then one command ----------------
    repeat (2) @(negedge clk);
    check_eq("rst_strobe", {31'd0, write_strobe}, 32'd0);
    check_eq("rst_addr",   {29'd0, address}, 32'd0);
    check_eq("rst_data",   {27'd0, data}, 32'd0);
    check_eq("rst_busy",   {31'd0, busy}, 32'd0);
    check_eq("rst_count",  {29'd0, fifo_count}, 32'd0);
    check_eq("rst_ready",  {31'd0, cmd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t1_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_addr = 3'd3; cmd_data = 5'h15;
    @(negedge clk);                      // after E0
    cmd_valid = 1'b0;
    check_eq("t1_count_e0", {29'd0, fifo_count}, 32'd1);
    check_eq("t1_busy_e0",  {31'd0, busy}, 32'd1);
    @(negedge clk);                      // after E1
    check_eq("t1_addr_e1", {29'd0, address}, 32'd3);
    check_eq("t1_data_e1", {27'd0, data}, 32'h15);
    check_eq("t1_strobe_e1", {31'd0, write_strobe}, 32'd0);
    for (int k = 1; k <= 104; k++) begin
      @(negedge clk);
      if (k == 1)   check_eq("t1_strobe_e1p1",   {31'd0, write_strobe}, 32'd0);
      if (k == 2)   check_eq("t1_strobe_e1p2",   {31'd0, write_strobe}, 32'd1);
      if (k == 101) check_eq("t1_strobe_e1p101", {31'd0, write_strobe}, 32'd1);
      if (k == 102) check_eq("t1_strobe_e1p102", {31'd0, write_strobe}, 32'd0);
      if (k == 103) check_eq("t1_busy_e1p103",   {31'd0, busy}, 32'd1);
      if (k == 104) check_eq("t1_busy_e1p104",   {31'd0, busy}, 32'd0);
    end

    // ---------------- Test 2: four back-to-back commands ----------------
    clear_log();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_addr = 3'(i); cmd_data = 5'(i + 1);
      check_eq($sformatf("t2_ready_%0d", i), {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    wait_idle(600, "t2_idle");
    check_eq("t2_nwrites", rise_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < rise_q.size(); i++) begin
      check_eq($sformatf("t2_word_%0d", i), {24'd0, wr_q[i]}, {24'd0, 3'(i), 5'(i + 1)});
      if (i > 0) check_eq($sformatf("t2_pitch_%0d", i), rise_q[i] - rise_q[i-1], 32'd104);
    end
    if (fall_q.size() > 0 && rise_q.size() > 0)
      check_eq("t2_width", fall_q[0] - rise_q[0], 32'd100);
    else
      check_eq("t2_fall_seen", fall_q.size(), 32'd4);

    // ---------------- Test 3: six commands with cmd_valid held ----------------
    clear_log();
    full_checked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_addr = 3'(i); cmd_data = 5'(16 + i);
      accepted = 1'b0; guard = 0;
      while (!accepted && guard < 500) begin
        if (fifo_count == 3'd4 && !full_checked) begin
          check_eq("t3_ready_full", {31'd0, cmd_ready}, 32'd0);
          full_checked = 1'b1;
        end
        accepted = cmd_ready;
        @(negedge clk);
        guard++;
      end
      if (!accepted) check_eq($sformatf("t3_accept_%0d", i), {31'd0, cmd_ready}, 32'd1);
      acc_cyc[i] = cyc;
    end
    cmd_valid = 1'b0;
    check_eq("t3_full_seen", {31'd0, full_checked}, 32'd1);
    check_eq("t3_resume", acc_cyc[5] - acc_cyc[0], 32'd106);
    wait_idle(1000, "t3_idle");
    check_eq("t3_nwrites", rise_q.size(), 32'd6);
    for (int i = 0; i < 6 && i < wr_q.size(); i++)
      check_eq($sformatf("t3_word_%0d", i), {24'd0, wr_q[i]}, {24'd0, 3'(i), 5'(16 + i)});

    // ---------------- Test 4: push coincident with pop at count 2 ----------------
    clear_log();
    cmd_valid = 1'b1; cmd_addr = 3'd7; cmd_data = 5'd9;
    @(negedge clk);
    e0 = cyc;
    cmd_addr = 3'd6; cmd_data = 5'd10;
    @(negedge clk);
    cmd_addr = 3'd5; cmd_data = 5'd11;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("t4_count_pre", {29'd0, fifo_count}, 32'd2);
    while (cyc < e0 + 104) @(negedge clk);
    check_eq("t4_count_before_pop", {29'd0, fifo_count}, 32'd2);
    cmd_valid = 1'b1; cmd_addr = 3'd4; cmd_data = 5'd12;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("t4_count_after_pop", {29'd0, fifo_count}, 32'd2);
    check_eq("t4_addr_popped", {29'd0, address}, 32'd6);
    check_eq("t4_data_popped", {27'd0, data}, 32'd10);
    wait_idle(600, "t4_idle");
    check_eq("t4_nwrites", rise_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < wr_q.size(); i++)
      check_eq($sformatf("t4_word_%0d", i), {24'd0, wr_q[i]}, {24'd0, 3'(7 - i), 5'(9 + i)});

    // ---------------- Test 5: reset in the middle of a strobe ----------------
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_addr = 3'(i + 1); cmd_data = 5'(20 + i);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    guard = 0;
    while (!write_strobe && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    repeat (49) @(negedge clk);
    check_eq("t5_strobe_c50", {31'd0, write_strobe}, 32'd1);
    check_eq("t5_count_pre",  {29'd0, fifo_count}, 32'd2);
    clear_log();
    rst = 1'b1;
    #1;
    check_eq("t5_ready_in_rst", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_strobe", {31'd0, write_strobe}, 32'd0);
    check_eq("t5_addr",   {29'd0, address}, 32'd0);
    check_eq("t5_data",   {27'd0, data}, 32'd0);
    check_eq("t5_count",  {29'd0, fifo_count}, 32'd0);
    repeat (300) @(negedge clk);
    check_eq("t5_no_activity", rise_q.size(), 32'd0);
    check_eq("t5_addr_late",   {29'd0, address}, 32'd0);
    check_eq("t5_busy_late",   {31'd0, busy}, 32'd0);

    // ---------------- Test 6: minimum windows, 1/1/1 ----------------
    f_rise_q.delete(); f_fall_q.delete(); f_wr_q.delete();
    f_cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_cmd_addr = 3'(i + 2); f_cmd_data = 5'(i + 3);
      @(negedge clk);
    end
    f_cmd_valid = 1'b0;
    guard = 0;
    while ((f_busy || f_fifo_count != 3'd0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("t6_idle", {31'd0, f_busy}, 32'd0);
    check_eq("t6_nwrites", f_rise_q.size(), 32'd3);
    for (int i = 0; i < 3 && i < f_rise_q.size(); i++) begin
      check_eq($sformatf("t6_word_%0d", i), {24'd0, f_wr_q[i]}, {24'd0, 3'(i + 2), 5'(i + 3)});
      if (i < f_fall_q.size())
        check_eq($sformatf("t6_width_%0d", i), f_fall_q[i] - f_rise_q[i], 32'd1);
      if (i > 0) check_eq($sformatf("t6_pitch_%0d", i), f_rise_q[i] - f_rise_q[i-1], 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
